// File: rtl/bubble_outbuf_mc_if.sv
// bubble_outbuf_mc_if: control, serial-write and bubble-output signals of the multi-channel output buffer
interface bubble_outbuf_mc_if #(
  parameter int CHANNELS   = 4,
  parameter int DEPTH_LOG2 = 13
);
  logic                  BITWIDTH4;
  logic [2:0]            ACCTYPE;
  logic                  START;
  logic                  nBOUTCLKEN;
  logic                  nOUTBUFWRCLKEN;
  logic [DEPTH_LOG2+1:0] OUTBUFWRADDR;
  logic                  OUTBUFWRDATA;
  logic [CHANNELS-1:0]   DOUT;
  logic                  BUSY;
  logic                  DONE;
  logic                  WRDROP;
  modport master (
    output BITWIDTH4, ACCTYPE, START, nBOUTCLKEN, nOUTBUFWRCLKEN, OUTBUFWRADDR, OUTBUFWRDATA,
    input  DOUT, BUSY, DONE, WRDROP
  );
  modport slave (
    input  BITWIDTH4, ACCTYPE, START, nBOUTCLKEN, nOUTBUFWRCLKEN, OUTBUFWRADDR, OUTBUFWRDATA,
    output DOUT, BUSY, DONE, WRDROP
  );
endinterface

// File: rtl/bubble_outbuf_mc.sv
// bubble_outbuf_mc: per-channel bit RAMs filled serially, replayed as sync pattern plus boot or user page onto DOUT
module bubble_outbuf_mc #(
  parameter int CHANNELS   = 4,
  parameter int DEPTH_LOG2 = 13,
  parameter int SYNC_ZEROS = 64,
  parameter int BOOT_LEN   = 1927,
  parameter int USER_BASE  = 7168,
  parameter int PAGE_LEN   = 584
) (
  input logic MCLK,
  input logic RST,
  bubble_outbuf_mc_if.slave bus
);
  localparam int LW = $clog2(CHANNELS);
  localparam int KW = $clog2(SYNC_ZEROS + 2);
  localparam logic [2:0] ACC_BOOT = 3'b110;
  localparam logic [2:0] ACC_USER = 3'b111;
  localparam logic [DEPTH_LOG2-1:0] BOOT_LAST  = DEPTH_LOG2'(BOOT_LEN - 1);
  localparam logic [DEPTH_LOG2-1:0] USER_FIRST = DEPTH_LOG2'(USER_BASE);
  localparam logic [DEPTH_LOG2-1:0] USER_LAST  = DEPTH_LOG2'(USER_BASE + PAGE_LEN - 1);
  typedef enum logic [1:0] {IDLE, SYNC, DATA, FIN} state_t;
  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic                  boot_q, boot_d;
  logic [CHANNELS-1:0]   dout_q, dout_d;
  logic                  busy_q, busy_d, done_q, done_d, drop_q, drop_d;
  logic [CHANNELS-1:0]   rd, act;
  logic [LW-1:0]         wr_lane;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic                  wr_en, tick, same;
  assign act     = bus.BITWIDTH4 ? '1 : CHANNELS'(2'b11);
  assign wr_lane = bus.BITWIDTH4 ? LW'(CHANNELS - 1) - bus.OUTBUFWRADDR[LW-1:0] : LW'(!bus.OUTBUFWRADDR[0]);
  assign wr_addr = bus.BITWIDTH4 ? bus.OUTBUFWRADDR[LW+DEPTH_LOG2-1:LW] : bus.OUTBUFWRADDR[DEPTH_LOG2:1];
  assign wr_en   = !bus.nOUTBUFWRCLKEN && state_q == IDLE;
  assign tick    = !bus.nBOUTCLKEN;
  assign same    = bus.ACCTYPE == (boot_q ? ACC_BOOT : ACC_USER);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic mem [2**DEPTH_LOG2];
    always_ff @(posedge MCLK)
      if (wr_en && wr_lane == LW'(c)) mem[wr_addr] <= bus.OUTBUFWRDATA;
    assign rd[c] = mem[addr_q];
  end
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    boot_d  = boot_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (bus.START && bus.ACCTYPE == ACC_BOOT) begin
          state_d = SYNC;
          boot_d  = 1'b1;
          k_d     = '0;
        end else if (bus.START && bus.ACCTYPE == ACC_USER) begin
          state_d = DATA;
          boot_d  = 1'b0;
          addr_d  = USER_FIRST;
        end
      end
      SYNC: begin
        if (!same) state_d = IDLE;
        else if (tick) begin
          dout_d = ~CHANNELS'(k_q == KW'(SYNC_ZEROS));
          k_d    = k_q + 1'b1;
          if (k_q == KW'(SYNC_ZEROS + 1)) begin
            state_d = DATA;
            addr_d  = '0;
          end
        end
      end
      DATA: begin
        if (!same) state_d = IDLE;
        else if (tick) begin
          dout_d  = ~(rd & act);
          addr_d  = addr_q + 1'b1;
          state_d = addr_q == (boot_q ? BOOT_LAST : USER_LAST) ? FIN : DATA;
        end
      end
      default: state_d = IDLE;
    endcase
    dout_d = state_d == IDLE ? '1 : dout_d;
    busy_d = state_d != IDLE;
    done_d = state_d == FIN;
    drop_d = !bus.nOUTBUFWRCLKEN && state_q != IDLE;
  end
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      boot_q  <= 1'b0;
      dout_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      boot_q  <= boot_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end
  assign bus.DOUT   = dout_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.WRDROP = drop_q;
endmodule

// File: tb/tb_bubble_outbuf_mc.sv
// tb_bubble_outbuf_mc: directed checks of sync generation, boot/user replay, write decode, drops, abort and reset
module tb_bubble_outbuf_mc;
  localparam int CH = 4;
  localparam int D  = 13;
  logic MCLK = 1'b0;
  logic RST;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] pat [4] = '{4'b0011, 4'b1010, 4'b1100, 4'b0110};
  bubble_outbuf_mc_if #(.CHANNELS(CH), .DEPTH_LOG2(D)) bus ();
  bubble_outbuf_mc #(
    .CHANNELS(CH), .DEPTH_LOG2(D), .SYNC_ZEROS(64),
    .BOOT_LEN(4), .USER_BASE(0), .PAGE_LEN(1)
  ) dut (.MCLK(MCLK), .RST(RST), .bus(bus.slave));
  always #5 MCLK = ~MCLK;
  task automatic step;
    @(posedge MCLK);
    #1;
  endtask
  task automatic wr(input int a, input logic d);
    bus.OUTBUFWRADDR = (D+2)'(a);
    bus.OUTBUFWRDATA = d;
    bus.nOUTBUFWRCLKEN = 1'b0;
    step();
    bus.nOUTBUFWRCLKEN = 1'b1;
  endtask
  task automatic tick;
    bus.nBOUTCLKEN = 1'b0;
    step();
    bus.nBOUTCLKEN = 1'b1;
  endtask
  task automatic start(input logic [2:0] acc);
    bus.ACCTYPE = acc;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
  endtask
  task automatic test_reset;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    n_chk++; if (bus.DOUT !== 4'hF) begin n_fail++; $display("FAIL reset_dout got %h want f", bus.DOUT); end
    n_chk++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
    n_chk++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.DONE); end
    n_chk++; if (bus.WRDROP !== 1'b0) begin n_fail++; $display("FAIL reset_wrdrop got %b want 0", bus.WRDROP); end
  endtask
  task automatic test_2ch_user;
    bus.BITWIDTH4 = 1'b0;
    wr(0, 1'b1);
    wr(1, 1'b0);
    n_chk++; if (bus.WRDROP !== 1'b0) begin n_fail++; $display("FAIL idle_write_drop got %b want 0", bus.WRDROP); end
    start(3'b111);
    n_chk++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL user2_busy got %b want 1", bus.BUSY); end
    tick();
    n_chk++; if (bus.DOUT !== 4'b1101) begin n_fail++; $display("FAIL user2_dout got %b want 1101", bus.DOUT); end
    n_chk++; if (bus.DONE !== 1'b1) begin n_fail++; $display("FAIL user2_done got %b want 1", bus.DONE); end
    step();
    n_chk++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL user2_done_once got %b want 0", bus.DONE); end
    n_chk++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL user2_idle_busy got %b want 0", bus.BUSY); end
    n_chk++; if (bus.DOUT !== 4'hF) begin n_fail++; $display("FAIL user2_idle_dout got %h want f", bus.DOUT); end
  endtask
  task automatic test_4ch_boot;
    int bad = 0;
    bus.BITWIDTH4 = 1'b1;
    for (int a = 0; a < 4; a++)
      for (int j = 0; j < 4; j++) wr(a * 4 + j, pat[a][3-j]);
    start(3'b110);
    n_chk++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL boot_busy got %b want 1", bus.BUSY); end
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.DOUT !== 4'hF) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL boot_sync_zeros got %0d bad ticks want 0", bad); end
    tick();
    n_chk++; if (bus.DOUT !== 4'hE) begin n_fail++; $display("FAIL boot_sync_one got %h want e", bus.DOUT); end
    tick();
    n_chk++; if (bus.DOUT !== 4'hF) begin n_fail++; $display("FAIL boot_sync_dc got %h want f", bus.DOUT); end
    for (int a = 0; a < 4; a++) begin
      tick();
      n_chk++; if (bus.DOUT !== ~pat[a]) begin n_fail++; $display("FAIL boot_data%0d got %b want %b", a, bus.DOUT, ~pat[a]); end
    end
    n_chk++; if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL boot_fin got done=%b busy=%b want 1 1", bus.DONE, bus.BUSY); end
    step();
    n_chk++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.DOUT !== 4'hF) begin
      n_fail++; $display("FAIL boot_end got done=%b busy=%b dout=%h want 0 0 f", bus.DONE, bus.BUSY, bus.DOUT);
    end
  endtask
  task automatic test_wrdrop;
    start(3'b111);
    bus.OUTBUFWRADDR = '0;
    bus.OUTBUFWRDATA = ~pat[0][3];
    bus.nOUTBUFWRCLKEN = 1'b0;
    bus.nBOUTCLKEN = 1'b0;
    step();
    bus.nOUTBUFWRCLKEN = 1'b1;
    bus.nBOUTCLKEN = 1'b1;
    n_chk++; if (bus.WRDROP !== 1'b1) begin n_fail++; $display("FAIL wrdrop_pulse got %b want 1", bus.WRDROP); end
    n_chk++; if (bus.DOUT !== ~pat[0]) begin n_fail++; $display("FAIL wrdrop_read got %b want %b", bus.DOUT, ~pat[0]); end
    step();
    n_chk++; if (bus.WRDROP !== 1'b0) begin n_fail++; $display("FAIL wrdrop_once got %b want 0", bus.WRDROP); end
    start(3'b111);
    tick();
    n_chk++; if (bus.DOUT !== ~pat[0]) begin n_fail++; $display("FAIL wrdrop_ram_kept got %b want %b", bus.DOUT, ~pat[0]); end
    step();
  endtask
  task automatic test_abort;
    int seen = 0;
    start(3'b110);
    repeat (64) tick();
    tick();
    n_chk++; if (bus.DOUT !== 4'hE) begin n_fail++; $display("FAIL abort_pre got %h want e", bus.DOUT); end
    bus.ACCTYPE = 3'b000;
    step();
    n_chk++; if (bus.BUSY !== 1'b0 || bus.DOUT !== 4'hF) begin
      n_fail++; $display("FAIL abort_idle got busy=%b dout=%h want 0 f", bus.BUSY, bus.DOUT);
    end
    repeat (5) begin
      if (bus.DONE) seen++;
      step();
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
  endtask
  task automatic test_start_ignored;
    start(3'b101);
    n_chk++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL start_bad_acc got busy=%b want 0", bus.BUSY); end
    start(3'b111);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    n_chk++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL start_busy_ignored got %b want 1", bus.BUSY); end
    tick();
    n_chk++; if (bus.DONE !== 1'b1 || bus.DOUT !== ~pat[0]) begin
      n_fail++; $display("FAIL start_busy_session got done=%b dout=%b want 1 %b", bus.DONE, bus.DOUT, ~pat[0]);
    end
    step();
  endtask
  task automatic test_reset_mid;
    start(3'b110);
    repeat (66) tick();
    tick();
    tick();
    n_chk++; if (bus.DOUT !== ~pat[1]) begin n_fail++; $display("FAIL rst_mid_pre got %b want %b", bus.DOUT, ~pat[1]); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_chk++; if (bus.BUSY !== 1'b0 || bus.DOUT !== 4'hF) begin
      n_fail++; $display("FAIL rst_mid got busy=%b dout=%h want 0 f", bus.BUSY, bus.DOUT);
    end
    RST = 1'b1;
    bus.ACCTYPE = 3'b110;
    bus.START = 1'b1;
    step();
    RST = 1'b0;
    bus.START = 1'b0;
    n_chk++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_vs_start got busy=%b want 0", bus.BUSY); end
    start(3'b110);
    repeat (66) tick();
    for (int a = 0; a < 4; a++) begin
      tick();
      n_chk++; if (bus.DOUT !== ~pat[a]) begin n_fail++; $display("FAIL rst_ram_kept%0d got %b want %b", a, bus.DOUT, ~pat[a]); end
    end
    step();
    n_chk++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_final_busy got %b want 0", bus.BUSY); end
  endtask
  initial begin
    RST = 1'b1;
    bus.BITWIDTH4 = 1'b0;
    bus.ACCTYPE = 3'b000;
    bus.START = 1'b0;
    bus.nBOUTCLKEN = 1'b1;
    bus.nOUTBUFWRCLKEN = 1'b1;
    bus.OUTBUFWRADDR = '0;
    bus.OUTBUFWRDATA = 1'b0;
    test_reset();
    test_2ch_user();
    test_4ch_boot();
    test_wrdrop();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bubble_outbuf_mc.md
Name: bubble_outbuf_mc

Overview:
- Parametrised multi-channel bubble output buffer for the emulator core.
- Holds CHANNELS independent 1-bit-wide block RAMs of 2^DEPTH_LOG2 bits each. The SPI loader fills them through a serial write port.
- Replays bootloader or user-page sessions onto DOUT under a sequencer driven by the timing generator's clock-enable ticks.
- Generates the sync pattern internally and owns its read addressing. It replaces the external cycle-number address and the preloaded pattern.

Parameters:
- CHANNELS, 4, number of physical data channels (2 or 4).
- DEPTH_LOG2, 13, address width per channel RAM.
- SYNC_ZEROS, 64, count of logic-0 sync bits before the sync 1.
- BOOT_LEN, 1927, bootloader data bits per channel, read from address 0.
- USER_BASE, 7168, first RAM address of the user page.
- PAGE_LEN, 584, user page bits per channel.

Ports:
- MCLK  in  1  48 MHz clock.
- RST  in  1  synchronous reset, active-high.
- BITWIDTH4  in  1  0 = 2 active channels, 1 = all CHANNELS active.
- ACCTYPE  in  3  access type: 3'b110 = BOOT, 3'b111 = USER, others = none.
- START  in  1  one-cycle pulse; begins a session for the current ACCTYPE.
- nBOUTCLKEN  in  1  active-low output bit tick.
- nOUTBUFWRCLKEN  in  1  active-low write strobe.
- OUTBUFWRADDR  in  DEPTH_LOG2+2  serial write address (channel lane in LSBs).
- OUTBUFWRDATA  in  1  write data bit.
- DOUT  out  CHANNELS  bubble data, active-low (1 = no bubble).
- BUSY  out  1  session in progress.
- DONE  out  1  one-cycle pulse at session end.
- WRDROP  out  1  one-cycle pulse when a write strobe is rejected.

Behaviour:
- **Clock and reset.** One clock, MCLK. RST is synchronous and active-high. Reset puts the FSM in IDLE, drives DOUT to all 1, drives BUSY/DONE/WRDROP to 0, and clears the counters. RAM contents are preserved across reset.
- **Active channels.** A = 2 when BITWIDTH4 = 0, otherwise CHANNELS. Channels at index A and above always drive 1.
- **Write lane decode.**
  - L = log2(A). Lane = (A-1) - OUTBUFWRADDR[L-1:0]; RAM address = OUTBUFWRADDR[L+DEPTH_LOG2-1:L].
  - In 2-channel mode, address bit 0 = 0 writes ch1 and bit 0 = 1 writes ch0.
- **Write acceptance.**
  - A write commits on an MCLK edge with nOUTBUFWRCLKEN = 0, but only while in IDLE.
  - A strobe arriving in any other state is dropped, and WRDROP pulses the next cycle.
- **FSM states:** IDLE, SYNC, DATA, FIN.
  - IDLE: on START with ACCTYPE = BOOT, go to SYNC; with ACCTYPE = USER, go to DATA with addr = USER_BASE. START with any other ACCTYPE is ignored. BUSY = 1 in every state except IDLE.
  - SYNC: each tick (nBOUTCLKEN = 0) advances a bit counter k.
    - ch0 data = 0 for k < SYNC_ZEROS, 1 at k = SYNC_ZEROS, 0 at k = SYNC_ZEROS+1. The last is the don't-care bit, driven as 0.
    - All other channels carry data 0.
    - After the tick with k = SYNC_ZEROS+1, go to DATA with addr = 0.
  - DATA: each tick registers RAM[addr] for every active channel and increments addr.
    - The session ends on the tick that reads the last address: BOOT_LEN-1 for BOOT, USER_BASE+PAGE_LEN-1 for USER. The FSM then goes to FIN.
    - addr wraps modulo 2^DEPTH_LOG2.
  - FIN: DONE = 1 for exactly one cycle, then go to IDLE.
- **Output timing.**
  - DOUT = ~data, registered. It updates on the tick edge, so it is visible the cycle after the tick.
  - DOUT holds between ticks. The last data bit holds through FIN.
  - On entry to IDLE, DOUT returns to all 1 (empty propagation line).
- **Abort.** If ACCTYPE leaves the session's type while in SYNC or DATA, the next edge forces IDLE and DOUT all 1. No DONE pulse is generated.
- **Simultaneous events.**
  - START while not IDLE is ignored.
  - A tick and a write strobe on the same cycle in DATA: the read proceeds and the write is dropped with WRDROP.
  - A START on the same edge as RST: RST wins.

Test Plan:
- 2ch mode, IDLE: write addr 0 data 1 and addr 1 data 0, then a USER session with USER_BASE=0 and PAGE_LEN=1 → first DOUT after the tick: DOUT[1]=0, DOUT[0]=1; DOUT[3:2]=11; DONE pulses once.
- BOOT session, 64 ticks → DOUT[0]=1 each; tick 65 → DOUT[0]=0; tick 66 → DOUT[0]=1; then BOOT_LEN data ticks; BUSY drops the cycle after the DONE pulse.
- 4ch mode: write lanes addr 4..7 with pattern 1010 → the read at RAM address 1 gives DOUT[3:0]=0101 (inverted lanes 3..0 = data of addr 4..7).
- Write strobe during DATA → RAM unchanged (verified by a later session), WRDROP=1 for one cycle.
- ACCTYPE changes from 110 to 000 mid-SYNC → next cycle BUSY=0, DOUT=all 1, no DONE.
- Assert RST mid-DATA → next cycle DOUT=all 1, BUSY=0; a later session reads the pre-reset RAM contents intact.
